// File: rtl/instr_mem_responder.sv
// Responder side of the instruction-fetch handshake: word ROM with programmable
// latency, redirect restart and abort. Optional counters via IMEM_PERF_CNT_EN.
module instr_mem_responder #(
    parameter int          DEPTH        = 1024,
    parameter int          LATENCY      = 2,
    parameter logic [31:0] ILLEGAL_INSN = 32'h0000_0000,
    localparam int         AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   mem_addr,
    input  logic          mem_read,
    output logic [31:0]   mem_data,
    output logic          mem_ready,
    output logic          mem_error,
    output logic          busy,
`ifdef IMEM_PERF_CNT_EN
    output logic [31:0]   perf_served,
    output logic [31:0]   perf_aborted,
`endif
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam bit         SINGLE_CYCLE = (LATENCY == 1);
    localparam logic [3:0] CNT_LOAD     = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_t      r_state;
    logic [31:0] r_lat_addr;
    logic [3:0]  r_cnt;
    logic [31:0] r_rd_data;
    logic        r_rd_err;
    logic [31:0] r_mem [DEPTH];

    logic        w_accept;
    logic        w_restart;
    logic        w_enter_resp;
    logic        w_addr_err;
    logic        w_gate;
    logic [31:0] w_rd_addr;

    // w_rd_addr is the address lat_addr will hold after this edge.
    always_comb begin
        w_accept     = (r_state == IDLE) && mem_read;
        w_restart    = (r_state == WAIT) && mem_read && (mem_addr != r_lat_addr);
        w_enter_resp = ((w_accept || w_restart) && SINGLE_CYCLE) ||
                       ((r_state == WAIT) && mem_read && !w_restart && (r_cnt == 4'd0));
        w_rd_addr    = (w_accept || w_restart) ? mem_addr : r_lat_addr;
        w_addr_err   = (w_rd_addr[1:0] != 2'b00) || (|w_rd_addr[31:AW+2]);
        w_gate       = (r_state == RESP) && mem_read && (mem_addr == r_lat_addr);
    end

    // Strobe is gated combinationally so a same-cycle redirect hides stale data.
    assign mem_ready = w_gate;
    assign mem_data  = (r_state == RESP) ? r_rd_data : 32'h0;
    assign mem_error = (r_state == RESP) && r_rd_err;
    assign busy      = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_lat_addr <= 32'h0;
            r_cnt      <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mem_read) begin
                        r_lat_addr <= mem_addr;
                        r_cnt      <= CNT_LOAD;
                        r_state    <= SINGLE_CYCLE ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!mem_read) begin
                        r_state <= IDLE;
                    end else if (w_restart) begin
                        r_lat_addr <= mem_addr;
                        r_cnt      <= CNT_LOAD;
                        if (SINGLE_CYCLE) r_state <= RESP;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: the array and its read register are deliberately left without reset
    // so the array maps onto block RAM; outputs are masked by state instead.
    // Non-blocking writes also give read-before-write on a same-word collision.
    always_ff @(posedge clk) begin
        if (prog_we) r_mem[prog_addr] <= prog_data;
        if (w_enter_resp) begin
            r_rd_err  <= w_addr_err;
            r_rd_data <= w_addr_err ? ILLEGAL_INSN : r_mem[w_rd_addr[AW+1:2]];
        end
    end

`ifdef IMEM_PERF_CNT_EN
    logic w_abort;
    assign w_abort = ((r_state == WAIT) && !mem_read) || w_restart ||
                     ((r_state == RESP) && !w_gate);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_served  <= 32'h0;
            perf_aborted <= 32'h0;
        end else begin
            if (w_gate && (perf_served != 32'hFFFF_FFFF))
                perf_served <= perf_served + 32'd1;
            if (w_abort && (perf_aborted != 32'hFFFF_FFFF))
                perf_aborted <= perf_aborted + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: LATENCY=2 and LATENCY=1 instances,
// expected responses queued at request time and popped on each mem_ready.
module tb_instr_mem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] ILL   = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic        mem_read = 1'b0;
    logic [31:0] m1_addr = 32'h0;
    logic        m1_read = 1'b0;
    logic        prog_we = 1'b0;
    logic [9:0]  prog_addr = 10'h0;
    logic [31:0] prog_data = 32'h0;

    logic [31:0] mem_data, m1_data;
    logic        mem_ready, mem_error, busy;
    logic        m1_ready, m1_error, m1_busy;
`ifdef IMEM_PERF_CNT_EN
    logic [31:0] perf_served, perf_aborted, m1_served, m1_aborted;
`endif

    exp_t        exp_q[$];
    logic [31:0] model_mem [DEPTH];
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    instr_mem_responder #(.DEPTH(DEPTH), .LATENCY(2), .ILLEGAL_INSN(ILL)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_data(mem_data), .mem_ready(mem_ready), .mem_error(mem_error), .busy(busy),
`ifdef IMEM_PERF_CNT_EN
        .perf_served(perf_served), .perf_aborted(perf_aborted),
`endif
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    instr_mem_responder #(.DEPTH(DEPTH), .LATENCY(1), .ILLEGAL_INSN(ILL)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(m1_addr), .mem_read(m1_read),
        .mem_data(m1_data), .mem_ready(m1_ready), .mem_error(m1_error), .busy(m1_busy),
`ifdef IMEM_PERF_CNT_EN
        .perf_served(m1_served), .perf_aborted(m1_aborted),
`endif
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    function automatic exp_t model_read(input logic [31:0] a);
        exp_t e;
        if ((a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4))) begin
            e.data = ILL;
            e.err  = 1'b1;
        end else begin
            e.data = model_mem[a[11:2]];
            e.err  = 1'b0;
        end
        return e;
    endfunction

    task automatic pop_check(input string tag, input logic [31:0] d, input logic e);
        exp_t x;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL %s: response %h arrived with empty scoreboard", tag, d);
            return;
        end
        x = exp_q.pop_front();
        check({tag, "_data"}, d, x.data);
        check({tag, "_err"}, 32'(e), 32'(x.err));
    endtask

    task automatic prog(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        model_mem[a] = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // One cycle: drive at the falling edge, sample 1 ns later.
    task automatic step(input logic rd, input logic [31:0] a);
        @(negedge clk);
        mem_read = rd;
        mem_addr = a;
        #1;
    endtask

    task automatic step1(input logic rd, input logic [31:0] a);
        @(negedge clk);
        m1_read = rd;
        m1_addr = a;
        #1;
    endtask

    // Accept from IDLE, hold the request, expect the strobe exactly 2 cycles later.
    task automatic run_read(input string tag, input logic [31:0] a);
        int n;
        exp_q.push_back(model_read(a));
        step(1'b1, a);
        check({tag, "_acc_busy"}, 32'(busy), 32'd0);
        check({tag, "_acc_rdy"}, 32'(mem_ready), 32'd0);
        n = 0;
        while (!mem_ready && n < 8) begin
            step(1'b1, a);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd2);
        pop_check(tag, mem_data, mem_error);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int strobes;

        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_data", mem_data, 32'd0);
        check("rst_error", 32'(mem_error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef IMEM_PERF_CNT_EN
        check("rst_served", perf_served, 32'd0);
        check("rst_aborted", perf_aborted, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) prog(10'(i), 32'hC0DE_0000 | 32'(i));
        prog(10'd3, 32'hDEAD_BEEF);
        prog(10'd5, 32'hAAAA_AAAA);
        prog(10'd8, 32'h8888_0008);

        // Basic read, then back-to-back accept right after RESP.
        run_read("t1", 32'h0C);
        run_read("t1_next", 32'h0C);

        // Redirect during WAIT restarts the access on the new address.
        step(1'b1, 32'h10);
        check("t2_acc_busy", 32'(busy), 32'd0);
        step(1'b1, 32'h20);
        exp_q.push_back(model_read(32'h20));
        check("t2_redirect_rdy", 32'(mem_ready), 32'd0);
        step(1'b1, 32'h20);
        check("t2_wait_rdy", 32'(mem_ready), 32'd0);
        step(1'b1, 32'h20);
        check("t2_strobe", 32'(mem_ready), 32'd1);
        pop_check("t2", mem_data, mem_error);
`ifdef IMEM_PERF_CNT_EN
        check("t2_aborted", perf_aborted, 32'd1);
`endif
        step(1'b0, 32'h0);

        // Misaligned and out-of-range addresses.
        run_read("t3_mis", 32'h02);
        run_read("t3_oor", 32'(DEPTH * 4));
        step(1'b0, 32'h0);

        // Abort by dropping mem_read in WAIT.
        step(1'b1, 32'h0C);
        step(1'b0, 32'h0C);
        check("t4_abort_busy", 32'(busy), 32'd1);
        check("t4_abort_rdy", 32'(mem_ready), 32'd0);
        step(1'b0, 32'h0C);
        check("t4_idle_busy", 32'(busy), 32'd0);
        check("t4_idle_rdy", 32'(mem_ready), 32'd0);
`ifdef IMEM_PERF_CNT_EN
        check("t4_aborted", perf_aborted, 32'd2);
`endif

        // Reset asserted while in RESP.
        step(1'b1, 32'h0C);
        step(1'b1, 32'h0C);
        step(1'b1, 32'h0C);
        check("t4_pre_rst_rdy", 32'(mem_ready), 32'd1);
        check("t4_pre_rst_data", mem_data, 32'hDEAD_BEEF);
        rst_n    = 1'b0;
        mem_read = 1'b0;
        #1;
        check("t4_rst_rdy", 32'(mem_ready), 32'd0);
        check("t4_rst_data", mem_data, 32'd0);
        check("t4_rst_err", 32'(mem_error), 32'd0);
        check("t4_rst_busy", 32'(busy), 32'd0);
`ifdef IMEM_PERF_CNT_EN
        check("t4_rst_served", perf_served, 32'd0);
        check("t4_rst_aborted", perf_aborted, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_read("t4_after_rst", 32'h0C);
        step(1'b0, 32'h0);

        // Program-port write collides with RESP-entry read of the same word.
        exp_q.push_back(model_read(32'h14));
        step(1'b1, 32'h14);
        check("t5_acc_busy", 32'(busy), 32'd0);
        step(1'b1, 32'h14);
        prog_we   = 1'b1;
        prog_addr = 10'd5;
        prog_data = 32'h1111_1111;
        step(1'b1, 32'h14);
        prog_we = 1'b0;
        model_mem[5] = 32'h1111_1111;
        check("t5_strobe", 32'(mem_ready), 32'd1);
        pop_check("t5_old", mem_data, mem_error);
        run_read("t5_new", 32'h14);
        step(1'b0, 32'h0);

        // LATENCY=1: ten sequential fetches, one strobe every two cycles.
        strobes = 0;
        for (int k = 0; k < 10; k++) begin
            exp_q.push_back(model_read(32'(4 * k)));
            step1(1'b1, 32'(4 * k));
            check("t6_acc_rdy", 32'(m1_ready), 32'd0);
            check("t6_acc_busy", 32'(m1_busy), 32'd0);
            step1(1'b1, 32'(4 * k));
            if (m1_ready) strobes++;
            pop_check("t6", m1_data, m1_error);
        end
        step1(1'b0, 32'h0);
        check("t6_strobes", 32'(strobes), 32'd10);
`ifdef IMEM_PERF_CNT_EN
        check("t6_served", m1_served, 32'd10);
`endif
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
Responder end of the instruction-memory fetch interface (mem_addr/mem_read/mem_data/mem_ready). Models a word-organised instruction ROM with configurable access latency, tracks the initiator's address every cycle, and aborts or restarts an in-flight access when the fetch unit redirects. Sits between the fetch unit and the program image. A side program port loads the image during boot or test.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two; AW = $clog2(DEPTH)
LATENCY, 2, cycles from request acceptance to mem_ready; legal range 1..15
ILLEGAL_INSN, 32'h0000_0000, data returned for misaligned or out-of-range addresses

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
mem_addr  input  32  byte address from fetch unit
mem_read  input  1  read request, level
mem_data  output  32  instruction word, valid when mem_ready=1
mem_ready  output  1  response strobe for the current mem_addr
mem_error  output  1  qualifies mem_ready: misaligned or out-of-range access
busy  output  1  access in flight (state WAIT or RESP)
prog_we  input  1  program-port write enable
prog_addr  input  AW  program-port word index
prog_data  input  32  program-port write data

Behaviour:
- States: IDLE, WAIT, RESP. Registers: lat_addr[31:0], cnt[3:0], rd_data[31:0], rd_err.
- Reset (async): state=IDLE, mem_data=0, mem_ready=0, mem_error=0, busy=0, cnt=0, lat_addr=0. Array contents are not cleared.
- IDLE with mem_read=1 in cycle T (accept): lat_addr<=mem_addr.
  - LATENCY=1: go to RESP.
  - Otherwise: go to WAIT with cnt<=LATENCY-2.
- WAIT, each cycle:
  - If mem_read=0: go to IDLE (abort).
  - Else if mem_addr!=lat_addr: reload lat_addr<=mem_addr and cnt<=LATENCY-2, or go to RESP if LATENCY=1 (restart).
  - Else if cnt==0: go to RESP.
  - Else cnt<=cnt-1.
- Array read on every transition into RESP: rd_data<=array[lat_addr_next[AW+1:2]], rd_err computed from the same address. Result: mem_ready first rises exactly LATENCY cycles after the accept cycle.
- RESP: mem_ready = (state==RESP) && mem_read && (mem_addr==lat_addr). This gate is combinational so a redirect in the same cycle suppresses a stale strobe.
  - mem_data=rd_data and mem_error=rd_err whenever state==RESP; otherwise mem_data=0 and mem_error=0.
  - Leaves to IDLE unconditionally after one cycle.
  - If the gate fails, no handshake occurs and the access counts as aborted.
  - Throughput: one word per LATENCY+1 cycles (one IDLE bubble).
- Error rule: mem_addr[1:0]!=0, or mem_addr>=DEPTH*4 → rd_data=ILLEGAL_INSN, rd_err=1. The array is not indexed. The response timing is unchanged.
- Program port: write at posedge when prog_we=1, independent of state. On a collision with the RESP-entry read of the same word, the read returns the old data (read-before-write).
- busy = (state!=IDLE).
- Reset mid-access: the response is dropped with no strobe. The next request after reset release is accepted normally.

Optional Feature:
Macro IMEM_PERF_CNT_EN.
- Defined: adds output ports perf_served[31:0] and perf_aborted[31:0], reset to 0, saturating at 32'hFFFF_FFFF.
  - perf_served increments on each mem_ready=1 cycle.
  - perf_aborted increments on each WAIT abort, WAIT restart, or RESP with a failed gate.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
1. Preload word 3=32'hDEAD_BEEF via prog port; LATENCY=2; hold mem_read=1, mem_addr=32'h0C from cycle T → mem_ready=1, mem_data=32'hDEAD_BEEF, mem_error=0 at T+2 only; IDLE at T+3; next accept at T+3.
2. Accept addr 32'h10 at T; change mem_addr to 32'h20 at T+1 → restart, no strobe for 32'h10; mem_ready with array[8] at T+3; perf_aborted=1 if IMEM_PERF_CNT_EN.
3. mem_addr=32'h02 (misaligned), then mem_addr=DEPTH*4 → each gets mem_ready=1, mem_error=1, mem_data=32'h0000_0000 after LATENCY cycles.
4. Drop mem_read during WAIT → return to IDLE, mem_ready stays 0. Assert rst_n=0 during RESP → outputs 0 immediately; array word 3 still reads 32'hDEAD_BEEF after release.
5. prog_we writes word 5=32'h1111_1111 on the same edge RESP is entered for addr 32'h14 (old value 32'hAAAA_AAAA) → mem_data=32'hAAAA_AAAA; the next read returns 32'h1111_1111.
6. LATENCY=1, 10 consecutive sequential requests → one strobe every 2 cycles; perf_served=10.
